// File: rtl/kf8259_acknowledge_master_pkg.sv
// ---------------------------------------------------------------------------
// kf8259_acknowledge_master_pkg
// Shared types and constants for the KF8259 CPU-side interrupt acknowledge
// master.
//   ack_state_t              : acknowledge sequencer states
//   ACK_PHASE_COUNTER_WIDTH  : width of the PULSE/GAP phase down-counter
//   ACK_TIMEOUT_COUNTER_WIDTH: width of the optional HOLD timeout counter
// ---------------------------------------------------------------------------
package kf8259_acknowledge_master_pkg;

    localparam int ACK_PHASE_COUNTER_WIDTH   = 4;
    localparam int ACK_TIMEOUT_COUNTER_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PULSE1 = 3'd1,
        GAP    = 3'd2,
        PULSE2 = 3'd3,
        HOLD   = 3'd4
    } ack_state_t;

endpackage

// File: rtl/kf8259_acknowledge_master_if.sv
// ---------------------------------------------------------------------------
// kf8259_acknowledge_master_if
// Bundles the 8259-facing and CPU-facing signals of the acknowledge master.
//   modport master : the acknowledge master itself
//   modport slave  : the environment (8259 + CPU core)
// Signals:
//   interrupt_request       INT from the 8259 (level)
//   cpu_interrupt_enable    CPU IF flag
//   cpu_ready               CPU at an instruction boundary
//   data_bus_in[7:0]        data bus as driven by the 8259
//   interrupt_acknowledge_n INTA# to the 8259, active-low
//   bus_lock                LOCK across the whole acknowledge sequence
//   vector[7:0]             captured vector
//   vector_valid            vector available to the CPU
//   vector_ready            CPU consumes the vector
//   busy                    sequencer not idle
//   ack_timeout             sticky HOLD timeout flag
// ---------------------------------------------------------------------------
interface kf8259_acknowledge_master_if;

    logic       interrupt_request;
    logic       cpu_interrupt_enable;
    logic       cpu_ready;
    logic [7:0] data_bus_in;
    logic       interrupt_acknowledge_n;
    logic       bus_lock;
    logic [7:0] vector;
    logic       vector_valid;
    logic       vector_ready;
    logic       busy;
    logic       ack_timeout;

    modport master (
        input  interrupt_request,
        input  cpu_interrupt_enable,
        input  cpu_ready,
        input  data_bus_in,
        input  vector_ready,
        output interrupt_acknowledge_n,
        output bus_lock,
        output vector,
        output vector_valid,
        output busy,
        output ack_timeout
    );

    modport slave (
        output interrupt_request,
        output cpu_interrupt_enable,
        output cpu_ready,
        output data_bus_in,
        output vector_ready,
        input  interrupt_acknowledge_n,
        input  bus_lock,
        input  vector,
        input  vector_valid,
        input  busy,
        input  ack_timeout
    );

endinterface

// File: rtl/kf8259_ack_phase_timer.sv
// ---------------------------------------------------------------------------
// kf8259_ack_phase_timer
// Loadable down-counter that saturates at zero.
//   clock      : system clock
//   reset_n    : asynchronous active-low reset (counter clears to 0)
//   load       : load strobe, takes priority over counting
//   load_value : value loaded on a load strobe
//   done       : counter is at zero
// A phase lasting N cycles is timed by loading N-1 on entry and leaving on
// the edge where done is seen.
// ---------------------------------------------------------------------------
module kf8259_ack_phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/kf8259_acknowledge_master.sv
// ---------------------------------------------------------------------------
// kf8259_acknowledge_master
// CPU-side interrupt acknowledge initiator for the KF8259. When INT is
// asserted and the CPU can take an interrupt, it drives the two-pulse INTA#
// sequence under bus lock, captures the vector byte on the closing edge of
// the second pulse, and offers it to the CPU through vector_valid /
// vector_ready.
// Parameters:
//   PULSE_WIDTH    (1..15)    cycles INTA# is low per pulse
//   GAP_WIDTH      (1..15)    cycles INTA# is high between pulses
//   TIMEOUT_CYCLES (1..65535) HOLD timeout, only with the macro below
// Ports:
//   clock, reset_n (asynchronous, active-low)
//   bus : kf8259_acknowledge_master_if.master (handshake / bus signals)
// Optional feature: define KF8259_ACK_TIMEOUT_EN to abandon HOLD after
// TIMEOUT_CYCLES edges without vector_ready and set the sticky ack_timeout.
// Without it HOLD waits indefinitely and ack_timeout is tied low.
// ---------------------------------------------------------------------------
module kf8259_acknowledge_master
    import kf8259_acknowledge_master_pkg::*;
#(
    parameter int PULSE_WIDTH    = 2,
    parameter int GAP_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                          clock,
    input logic                          reset_n,
    kf8259_acknowledge_master_if.master  bus
);

    localparam logic [ACK_PHASE_COUNTER_WIDTH-1:0] PULSE_LOAD =
        ACK_PHASE_COUNTER_WIDTH'(PULSE_WIDTH - 1);
    localparam logic [ACK_PHASE_COUNTER_WIDTH-1:0] GAP_LOAD =
        ACK_PHASE_COUNTER_WIDTH'(GAP_WIDTH - 1);

    ack_state_t state_reg, state_next;

    logic                               phase_load;
    logic [ACK_PHASE_COUNTER_WIDTH-1:0] phase_load_value;
    logic                               phase_done;
    logic                               capture;
    logic                               timeout_expired;

    logic       inta_n_reg,       inta_n_next;
    logic       bus_lock_reg,     bus_lock_next;
    logic       vector_valid_reg, vector_valid_next;
    logic       busy_reg,         busy_next;
    logic [7:0] vector_reg,       vector_next;

    kf8259_ack_phase_timer #(
        .WIDTH (ACK_PHASE_COUNTER_WIDTH)
    ) u_phase_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (phase_load),
        .load_value (phase_load_value),
        .done       (phase_done)
    );

    // -----------------------------------------------------------------------
    // State register (outputs are registered alongside, decoded from the
    // next state so they line up with the state they describe)
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            inta_n_reg       <= 1'b1;
            bus_lock_reg     <= 1'b0;
            vector_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            vector_reg       <= 8'h00;
        end else begin
            state_reg        <= state_next;
            inta_n_reg       <= inta_n_next;
            bus_lock_reg     <= bus_lock_next;
            vector_valid_reg <= vector_valid_next;
            busy_reg         <= busy_next;
            vector_reg       <= vector_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Once PULSE1 is entered the sequence runs to the end
    // regardless of the request terms; the 8259 then returns its spurious
    // vector, which is passed through untouched.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        phase_load       = 1'b0;
        phase_load_value = PULSE_LOAD;
        capture          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.interrupt_request && bus.cpu_interrupt_enable && bus.cpu_ready) begin
                    state_next       = PULSE1;
                    phase_load       = 1'b1;
                    phase_load_value = PULSE_LOAD;
                end
            end
            PULSE1: begin
                if (phase_done) begin
                    state_next       = GAP;
                    phase_load       = 1'b1;
                    phase_load_value = GAP_LOAD;
                end
            end
            GAP: begin
                if (phase_done) begin
                    state_next       = PULSE2;
                    phase_load       = 1'b1;
                    phase_load_value = PULSE_LOAD;
                end
            end
            PULSE2: begin
                if (phase_done) begin
                    state_next = HOLD;
                    capture    = 1'b1;
                end
            end
            HOLD: begin
                // A consume on the same edge as expiry wins over the timeout.
                if (bus.vector_ready || timeout_expired) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        inta_n_next       = !((state_next == PULSE1) || (state_next == PULSE2));
        bus_lock_next     = (state_next == PULSE1) || (state_next == GAP) ||
                            (state_next == PULSE2);
        vector_valid_next = (state_next == HOLD);
        busy_next         = (state_next != IDLE);
        // The vector survives HOLD exit until the next capture.
        vector_next       = capture ? bus.data_bus_in : vector_reg;
    end

    assign bus.interrupt_acknowledge_n = inta_n_reg;
    assign bus.bus_lock                = bus_lock_reg;
    assign bus.vector_valid            = vector_valid_reg;
    assign bus.busy                    = busy_reg;
    assign bus.vector                  = vector_reg;

`ifdef KF8259_ACK_TIMEOUT_EN
    localparam logic [ACK_TIMEOUT_COUNTER_WIDTH-1:0] TIMEOUT_LOAD =
        ACK_TIMEOUT_COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

    logic timeout_done;
    logic ack_timeout_reg, ack_timeout_next;

    // Loaded on HOLD entry; reaches zero on the TIMEOUT_CYCLES-th HOLD edge.
    kf8259_ack_phase_timer #(
        .WIDTH (ACK_TIMEOUT_COUNTER_WIDTH)
    ) u_timeout_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (capture),
        .load_value (TIMEOUT_LOAD),
        .done       (timeout_done)
    );

    assign timeout_expired = timeout_done;

    always_comb begin
        ack_timeout_next = ack_timeout_reg ||
                           ((state_reg == HOLD) && !bus.vector_ready && timeout_done);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_timeout_reg <= 1'b0;
        end else begin
            ack_timeout_reg <= ack_timeout_next;
        end
    end

    assign bus.ack_timeout = ack_timeout_reg;
`else
    assign timeout_expired = 1'b0;
    assign bus.ack_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_kf8259_acknowledge_master.sv
// ---------------------------------------------------------------------------
// tb_kf8259_acknowledge_master
// Randomized transaction-level bench. Expected outputs come from the timing
// rules of the acknowledge sequence (offsets from the starting edge E0),
// not from a copy of the state machine. Build with KF8259_ACK_TIMEOUT_EN
// defined to also exercise the HOLD timeout (TIMEOUT_CYCLES = 8).
// ---------------------------------------------------------------------------
module tb_kf8259_acknowledge_master;

    localparam int PW      = 2;
    localparam int GW      = 2;
    localparam int TO      = 8;
    localparam int SEQ_LEN = 2 * PW + GW;
`ifdef KF8259_ACK_TIMEOUT_EN
    localparam int MAX_HOLD = TO - 1;
`else
    localparam int MAX_HOLD = 20;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    kf8259_acknowledge_master_if ack_if ();

    kf8259_acknowledge_master #(
        .PULSE_WIDTH    (PW),
        .GAP_WIDTH      (GW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ack_if)
    );

    always #5 clock = ~clock;

    int         checks   = 0;
    int         failures = 0;
    int         txn_no   = 0;
    logic [7:0] model_vector  = 8'h00;
    logic       model_timeout = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outputs(input string where, input bit inta_n, input bit lock,
                                 input bit valid, input bit busy);
        check_value({where, ".inta_n"}, 32'(ack_if.interrupt_acknowledge_n), 32'(inta_n));
        check_value({where, ".bus_lock"}, 32'(ack_if.bus_lock), 32'(lock));
        check_value({where, ".vector_valid"}, 32'(ack_if.vector_valid), 32'(valid));
        check_value({where, ".busy"}, 32'(ack_if.busy), 32'(busy));
        check_value({where, ".vector"}, 32'(ack_if.vector), 32'(model_vector));
        check_value({where, ".ack_timeout"}, 32'(ack_if.ack_timeout), 32'(model_timeout));
    endtask

    // One acknowledge transaction.
    //   gate_cycles : idle cycles with a request term missing (miss_mask bits:
    //                 0=request, 1=IE, 2=ready; must be non-zero if used)
    //   drop_at     : offset from E0 at which request terms drop (-1 = never)
    //   vec         : byte the 8259 presents on the capture edge
    //   hold        : edges with vector_ready=0 before the consume edge
    //   keep_req    : leave all request terms high across the HOLD exit
    //   expect_to   : hold vector_ready low until the timeout fires
    task automatic run_txn(input int gate_cycles, input logic [2:0] miss_mask,
                           input int drop_at, input logic [7:0] vec, input int hold,
                           input bit keep_req, input bit expect_to);
        for (int i = 0; i < gate_cycles; i++) begin
            ack_if.interrupt_request    = !miss_mask[0];
            ack_if.cpu_interrupt_enable = !miss_mask[1];
            ack_if.cpu_ready            = !miss_mask[2];
            ack_if.vector_ready         = 1'($urandom_range(0, 1));
            ack_if.data_bus_in          = 8'($urandom);
            step();
            check_outputs("gate", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        ack_if.interrupt_request    = 1'b1;
        ack_if.cpu_interrupt_enable = 1'b1;
        ack_if.cpu_ready            = 1'b1;
        ack_if.data_bus_in          = ~vec;
        step();  // E0
        for (int t = 0; t < SEQ_LEN; t++) begin
            check_outputs("seq", !((t < PW) || (t >= PW + GW)), 1'b1, 1'b0, 1'b1);
            if (drop_at >= 0 && t >= drop_at) begin
                ack_if.interrupt_request    = 1'b0;
                ack_if.cpu_interrupt_enable = 1'($urandom_range(0, 1));
                ack_if.cpu_ready            = 1'($urandom_range(0, 1));
            end
            ack_if.vector_ready = 1'($urandom_range(0, 1));
            ack_if.data_bus_in  = (t == SEQ_LEN - 1) ? vec : ~vec;
            step();
        end
        model_vector = vec;
        if (expect_to) begin
            for (int i = 0; i < TO; i++) begin
                check_outputs("to_hold", 1'b1, 1'b0, 1'b1, 1'b1);
                ack_if.vector_ready = 1'b0;
                ack_if.data_bus_in  = 8'($urandom);
                step();
            end
            model_timeout = 1'b1;
            check_outputs("timeout", 1'b1, 1'b0, 1'b0, 1'b0);
        end else begin
            for (int i = 0; i < hold; i++) begin
                check_outputs("hold", 1'b1, 1'b0, 1'b1, 1'b1);
                ack_if.vector_ready = 1'b0;
                ack_if.data_bus_in  = 8'($urandom);
                step();
            end
            check_outputs("hold_last", 1'b1, 1'b0, 1'b1, 1'b1);
            ack_if.vector_ready      = 1'b1;
            ack_if.interrupt_request = keep_req;
            if (keep_req) begin
                ack_if.cpu_interrupt_enable = 1'b1;
                ack_if.cpu_ready            = 1'b1;
            end
            step();
            // Exactly one IDLE edge follows the consume, even with a live request.
            check_outputs("exit", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        ack_if.vector_ready = 1'b0;
        txn_no++;
        $display("txn %0d gate=%0d drop=%0d vec=0x%02h hold=%0d keep=%0d timeout=%0d",
                 txn_no, gate_cycles, drop_at, vec, hold, keep_req, expect_to);
    endtask

    task automatic reset_mid_pulse2();
        ack_if.interrupt_request    = 1'b1;
        ack_if.cpu_interrupt_enable = 1'b1;
        ack_if.cpu_ready            = 1'b1;
        step();  // E0
        for (int t = 0; t < PW + GW; t++) begin
            ack_if.data_bus_in = 8'($urandom);
            step();
        end
        check_value("rst.pulse2_inta_n", 32'(ack_if.interrupt_acknowledge_n), 32'(0));
        reset_n = 1'b0;
        #1;
        model_vector  = 8'h00;
        model_timeout = 1'b0;
        check_outputs("rst_async", 1'b1, 1'b0, 1'b0, 1'b0);
        ack_if.interrupt_request = 1'b0;
        step();
        check_outputs("rst_held", 1'b1, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step();
        check_outputs("rst_release", 1'b1, 1'b0, 1'b0, 1'b0);
        txn_no++;
        $display("txn %0d reset asserted in PULSE2", txn_no);
    endtask

    initial begin
        ack_if.interrupt_request    = 1'b0;
        ack_if.cpu_interrupt_enable = 1'b0;
        ack_if.cpu_ready            = 1'b0;
        ack_if.data_bus_in          = 8'h00;
        ack_if.vector_ready         = 1'b0;
        step();
        step();
        check_outputs("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step();
        check_outputs("post_reset", 1'b1, 1'b0, 1'b0, 1'b0);

        // Directed cases
        run_txn(0, 3'b001, -1, 8'h0A, 0, 1'b0, 1'b0);        // basic sequence
        run_txn(3, 3'b010, -1, 8'h5C, 1, 1'b0, 1'b0);        // IE low gates
        run_txn(3, 3'b100, -1, 8'hC3, 2, 1'b0, 1'b0);        // ready low gates
        run_txn(2, 3'b001, PW, 8'h0F, 0, 1'b0, 1'b0);        // request drops in GAP
        run_txn(1, 3'b110, -1, 8'hA5, MAX_HOLD, 1'b1, 1'b0); // backpressure, request held
        run_txn(0, 3'b001, -1, 8'h00, 0, 1'b1, 1'b0);        // back-to-back, vector 0x00
        run_txn(0, 3'b001, 0, 8'hFF, 3, 1'b0, 1'b0);         // drop at E0, vector 0xFF

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            int         gate;
            logic [2:0] mask;
            int         drop;
            gate = $urandom_range(0, 4);
            mask = 3'($urandom_range(1, 7));
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SEQ_LEN - 1)) : -1;
            run_txn(gate, mask, drop, 8'($urandom), $urandom_range(0, MAX_HOLD),
                    1'($urandom_range(0, 1)), 1'b0);
        end

        reset_mid_pulse2();
        run_txn(1, 3'b011, -1, 8'h3E, 2, 1'b0, 1'b0);

`ifdef KF8259_ACK_TIMEOUT_EN
        run_txn(0, 3'b001, -1, 8'h77, 0, 1'b0, 1'b1);        // timeout fires
        run_txn(2, 3'b100, -1, 8'h12, 1, 1'b0, 1'b0);        // flag stays sticky
        reset_n = 1'b0;
        #1;
        model_vector  = 8'h00;
        model_timeout = 1'b0;
        check_outputs("to_cleared", 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        run_txn(0, 3'b001, -1, 8'h99, 1, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
